// File: rtl/pdm_dec_pkg.sv
// Shared constants and helpers for the PDM decimator.
// PDM_DEC_ORDER2_EN selects a 2nd-order CIC; otherwise 1st order.
package pdm_dec_pkg;

`ifdef PDM_DEC_ORDER2_EN
   localparam int unsigned N = 2;
`else
   localparam int unsigned N = 1;
`endif
   localparam int unsigned W = 6 * N + 1;

   typedef logic [W-1:0] acc_t;

   function automatic logic [2:0] dec_sel_to_k(input logic [1:0] dec_sel);
      return 3'(dec_sel) + 3'd3;
   endfunction

   // Centre y around zero, normalise to 7 bits, then clamp.
   function automatic logic [6:0] scale_sat(input acc_t y, input logic [2:0] k);
      int nk;
      int s;
      nk = int'(N) * int'(k);
      s  = int'(y) - (32'sd1 <<< (nk - 1));
      if (nk < 7) begin
         s = s <<< (7 - nk);
      end else begin
         s = s >>> (nk - 7);
      end
      if (s > 63) begin
         s = 63;
      end else if (s < -64) begin
         s = -64;
      end
      return s[6:0];
   endfunction

endpackage

// File: rtl/pdm_dec_if.sv
// Pin bundle of the PDM decimator tile (dedicated inputs/outputs only).
// Same shape whether or not PDM_DEC_ORDER2_EN is defined.
interface pdm_dec_if;
   logic [7:0] ui_in;
   logic [7:0] uo_out;

   modport master (output ui_in, input uo_out);
   modport slave (input ui_in, output uo_out);
endinterface

// File: rtl/pdm_dec_cic.sv
// CIC integrators, frame counter and comb stage; y is valid while tick is high.
// PDM_DEC_ORDER2_EN adds the second integrator/comb pair.
module pdm_dec_cic
   import pdm_dec_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pdm_in,
   input  logic       en,
   input  logic [1:0] dec_sel,
   output acc_t       y,
   output logic       tick,
   output logic [1:0] frame_sel
);

   logic [5:0] cnt_q;
   logic [5:0] cnt_last;
   logic [1:0] sel_q;
   logic [1:0] frame_sel_q;
   logic       tick_q;
   logic       frame_end;
   acc_t       i1_q;
   acc_t       d1_q;
   acc_t       c1;

   assign cnt_last  = 6'h3f >> (2'd3 - sel_q);
   assign frame_end = en && (cnt_q == cnt_last);

`ifdef PDM_DEC_ORDER2_EN
   acc_t i2_q;
   acc_t d2_q;
   acc_t c2;

   assign c1 = i2_q - d1_q;
   assign c2 = c1 - d2_q;
   assign y  = c2;
`else
   assign c1 = i1_q - d1_q;
   assign y  = c1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         sel_q       <= '0;
         frame_sel_q <= '0;
         tick_q      <= 1'b0;
         i1_q        <= '0;
         d1_q        <= '0;
`ifdef PDM_DEC_ORDER2_EN
         i2_q        <= '0;
         d2_q        <= '0;
`endif
      end else begin
         tick_q <= frame_end;
         if (en) begin
            i1_q <= i1_q + acc_t'(pdm_in);
`ifdef PDM_DEC_ORDER2_EN
            i2_q <= i2_q + i1_q;
`endif
            cnt_q <= frame_end ? 6'd0 : cnt_q + 6'd1;
         end
         // The ratio used for scaling must be the one the finished frame ran at.
         if (frame_end) begin
            frame_sel_q <= sel_q;
            sel_q       <= dec_sel;
         end
         if (tick_q) begin
`ifdef PDM_DEC_ORDER2_EN
            d1_q <= i2_q;
            d2_q <= c1;
`else
            d1_q <= i1_q;
`endif
         end
      end
   end

   assign tick      = tick_q;
   assign frame_sel = frame_sel_q;

endmodule

// File: rtl/tt_um_micro_gfg_development_pdm_dec.sv
// PDM demodulator tile: pin mapping, output scaling and the sample/valid registers.
// Build with PDM_DEC_ORDER2_EN for the 2nd-order CIC.
module tt_um_micro_gfg_development_pdm_dec
   import pdm_dec_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   pdm_dec_if.slave bus
);

   acc_t       y;
   logic       tick;
   logic [1:0] frame_sel;
   logic [6:0] sample_q;
   logic       valid_q;
   logic       unused_ui;

   assign unused_ui = ^bus.ui_in[7:4];

   pdm_dec_cic u_cic (
      .clk       (clk),
      .rst_n     (rst_n),
      .pdm_in    (bus.ui_in[0]),
      .en        (bus.ui_in[3]),
      .dec_sel   (bus.ui_in[2:1]),
      .y         (y),
      .tick      (tick),
      .frame_sel (frame_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= tick;
         if (tick) begin
            sample_q <= scale_sat(y, dec_sel_to_k(frame_sel));
         end
      end
   end

   assign bus.uo_out = {valid_q, sample_q};

endmodule

// File: tb/tb_tt_um_micro_gfg_development_pdm_dec.sv
// Scoreboard bench: frame-level reference model pushes expected samples and
// their valid edge; a negedge monitor checks pulses, timing and held values.
module tb_tt_um_micro_gfg_development_pdm_dec;

   localparam int NN = int'(pdm_dec_pkg::N);
   localparam int MM = 1 << (6 * NN + 1);

   typedef struct {
      logic [6:0] sample;
      int         stamp;
   } exp_t;

   logic clk;
   logic rst_n;
   int   edge_n;
   int   n_tests;
   int   n_fail;
   exp_t exp_q[$];
   logic [6:0] last_exp;

   // Reference model state: running integrator totals per frame rules.
   int m_i1, m_i2, m_d1, m_d2, m_cnt, m_k;

   pdm_dec_if bus ();

   tt_um_micro_gfg_development_pdm_dec dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic int wrapm(input int v);
      return ((v % MM) + MM) % MM;
   endfunction

   function automatic logic [6:0] ref_sample(input int y, input int k);
      int nk, s, v, d;
      nk = NN * k;
      s  = y - (1 << (nk - 1));
      if (nk < 7) begin
         v = s * (1 << (7 - nk));
      end else begin
         d = 1 << (nk - 7);
         v = (s >= 0) ? s / d : -((-s + d - 1) / d);
      end
      if (v > 63) v = 63;
      if (v < -64) v = -64;
      return v[6:0];
   endfunction

   task automatic model_reset();
      m_i1 = 0; m_i2 = 0; m_d1 = 0; m_d2 = 0; m_cnt = 0; m_k = 3;
   endtask

   task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, got, req);
      end
   endtask

   // Apply one input cycle; the model advances on the same edge as the DUT.
   task automatic step(input logic pdm, input logic en, input logic [1:0] sel);
      int   y, c1, integ;
      exp_t e;
      bus.ui_in = {4'($urandom), en, sel, pdm};
      @(posedge clk);
      if (en) begin
         m_i2 = wrapm(m_i2 + m_i1);
         m_i1 = wrapm(m_i1 + int'(pdm));
         m_cnt++;
         if (m_cnt == (1 << m_k)) begin
            integ = (NN == 2) ? m_i2 : m_i1;
            c1    = wrapm(integ - m_d1);
            m_d1  = integ;
            y     = c1;
            if (NN == 2) begin
               y    = wrapm(c1 - m_d2);
               m_d2 = c1;
            end
            e.sample = ref_sample(y, m_k);
            e.stamp  = edge_n + 2;
            exp_q.push_back(e);
            m_cnt = 0;
            m_k   = 3 + int'(sel);
         end
      end
      #1;
   endtask

   // Monitor: every cycle out of reset is either the expected pulse or the held sample.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         last_exp = 7'd0;
      end else if (bus.uo_out[7]) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL valid_unexpected: edge %0d got %h required no pulse", edge_n, bus.uo_out);
         end else begin
            e = exp_q.pop_front();
            if (e.stamp != edge_n || bus.uo_out[6:0] !== e.sample) begin
               n_fail++;
               $display("FAIL valid_sample: got %h at edge %0d required %h at edge %0d",
                        bus.uo_out[6:0], edge_n, e.sample, e.stamp);
            end
            last_exp = e.sample;
         end
      end else begin
         n_tests++;
         if (exp_q.size() != 0 && exp_q[0].stamp <= edge_n) begin
            e = exp_q.pop_front();
            n_fail++;
            $display("FAIL valid_missing: edge %0d got %h required pulse %h",
                     edge_n, bus.uo_out, e.sample);
            last_exp = e.sample;
         end else if (bus.uo_out !== {1'b0, last_exp}) begin
            n_fail++;
            $display("FAIL hold: edge %0d got %h required %h", edge_n, bus.uo_out, {1'b0, last_exp});
         end
      end
   end

   initial begin
      int dens;
      logic [1:0] rsel;
      n_tests  = 0;
      n_fail   = 0;
      edge_n   = 0;
      last_exp = 7'd0;
      rst_n    = 1'b0;
      bus.ui_in = 8'h00;
      model_reset();

      repeat (5) begin
         bus.ui_in = 8'($urandom);
         @(negedge clk);
         check8("reset_hold", bus.uo_out, 8'h00);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Constant ones, then an asynchronous reset mid-frame.
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 2'd0);
      rst_n = 1'b0;
      model_reset();
      #1 check8("reset_async", bus.uo_out, 8'h00);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 2'd0);
      for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 2'd0);
      for (int i = 0; i < 64; i++) step(i[0] == 1'b0, 1'b1, 2'd1);

      // Back to R=8, then a 5-cycle enable gap inside one frame.
      for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1, 2'd0);
      for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0, 2'd0);
      for (int i = 0; i < 20; i++) step(1'($urandom), 1'b1, 2'd0);

      // dec_sel changes mid-frame.
      for (int i = 0; i < 4; i++) step(1'($urandom), 1'b1, 2'd0);
      for (int i = 0; i < 80; i++) step(1'($urandom), 1'b1, 2'd2);

      // Random density, enable and ratio changes.
      dens = 50;
      rsel = 2'd1;
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) dens = $urandom_range(0, 100);
         if ($urandom_range(0, 149) == 0) rsel = 2'($urandom);
         step($urandom_range(0, 99) < dens, $urandom_range(0, 9) != 0, rsel);
      end

      for (int i = 0; i < 150; i++) step(1'($urandom), 1'b1, 2'd0);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending pulses required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
